// File: rtl/vfifo_pkg.sv
// ---------------------------------------------------------------------------
// vfifo_pkg
// Shared constants for the versatile single-clock FIFO family.
//   vfifo_depth()        : number of words addressed by an ADDR_WIDTH pointer
//   VFIFO_AEMPTY_DEFAULT : default almost-empty threshold
//   VFIFO_AFULL_MARGIN   : default almost-full threshold distance from DEPTH
//   VFIFO_STD/VFIFO_FWFT : read-mode encoding for the FWFT parameter
// ---------------------------------------------------------------------------
package vfifo_pkg;

    localparam int VFIFO_STD  = 0;
    localparam int VFIFO_FWFT = 1;

    localparam int VFIFO_AEMPTY_DEFAULT = 4;
    localparam int VFIFO_AFULL_MARGIN   = 4;

    function automatic int vfifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/vfifo_dual_port_ram_sc_sw.sv
// ---------------------------------------------------------------------------
// vfifo_dual_port_ram_sc_sw
// Single-clock RAM, one write port, one read port. The read address is
// registered (loaded when raddr_ld_i is high); the data output is an
// asynchronous read of that registered address.
//   clk        : clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_ld_i : load enable for the read address register
//   raddr_i    : value loaded into the read address register
//   rdata_o    : mem[read address register]
// ---------------------------------------------------------------------------
module vfifo_dual_port_ram_sc_sw #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  raddr_ld_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] raddr_q;

    // Storage and read address carry no reset: contents are undefined
    // until written, and the address is always loaded before q is used.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (raddr_ld_i) begin
            raddr_q <= raddr_i;
        end
    end

    assign rdata_o = mem[raddr_q];

endmodule

// File: rtl/vfifo_fifo_sc.sv
// ---------------------------------------------------------------------------
// vfifo_fifo_sc
// Single-clock synchronous FIFO with standard or first-word-fall-through
// read mode, fill counter and registered status flags.
//   clk       : clock (rising edge)
//   rst       : synchronous active-high reset
//   d / wr    : write data / write request
//   rd        : read request (FWFT: pop the head word)
//   q         : read data
//   full      : count == DEPTH
//   afull     : count >= AFULL_LEVEL
//   empty     : no readable word
//   aempty    : count <= AEMPTY_LEVEL
//   count     : words written and not yet read (0..DEPTH)
//   overflow  : one-cycle pulse for a write while full
//   underflow : one-cycle pulse for a read while empty
// ---------------------------------------------------------------------------
module vfifo_fifo_sc
    import vfifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 9,
    parameter int FWFT         = VFIFO_STD,
    parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - VFIFO_AFULL_MARGIN,
    parameter int AEMPTY_LEVEL = VFIFO_AEMPTY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  wr,
    output logic                  full,
    output logic                  afull,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH     = vfifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_AEMPT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_TWO   = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam bit                    IS_FWFT   = (FWFT == VFIFO_FWFT);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  head_vld_q, head_vld_d;
    logic                  full_q, afull_q, empty_q, aempty_q;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;
    logic                  ram_ld;
    logic [ADDR_WIDTH-1:0] ram_raddr;

    // Requests presented together with reset are ignored entirely.
    assign wr_acc = wr && !full_q && !rst;
    assign rd_acc = rd && !empty_q && !rst;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        head_vld_d = head_vld_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // FWFT head-valid: after a pop, the next word is only exposed if it
        // was already in the RAM before this edge (count >= 2). A word
        // written this cycle becomes visible one cycle after it is counted,
        // so the RAM is never read at an address being written.
        if (rd_acc) begin
            head_vld_d = (count_q >= CNT_TWO);
        end else begin
            head_vld_d = head_vld_q || (count_q != '0);
        end

        if (rst) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            head_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        head_vld_q  <= head_vld_d;
        full_q      <= (count_d == CNT_DEPTH);
        afull_q     <= (count_d >= CNT_AFULL);
        aempty_q    <= (count_d <= CNT_AEMPT);
        empty_q     <= IS_FWFT ? !head_vld_d : (count_d == '0);
        overflow_q  <= !rst && wr && full_q;
        underflow_q <= !rst && rd && empty_q;
    end

    // Standard mode captures the head address only on an accepted read so q
    // holds between reads; FWFT mode keeps the address on the head pointer.
    assign ram_ld    = IS_FWFT ? 1'b1 : rd_acc;
    assign ram_raddr = IS_FWFT ? rd_ptr_d : rd_ptr_q;

    vfifo_dual_port_ram_sc_sw #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .we_i       (wr_acc),
        .waddr_i    (wr_ptr_q),
        .wdata_i    (d),
        .raddr_ld_i (ram_ld),
        .raddr_i    (ram_raddr),
        .rdata_o    (q)
    );

    assign full      = full_q;
    assign afull     = afull_q;
    assign empty     = empty_q;
    assign aempty    = aempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vfifo_fifo_sc.sv
// ---------------------------------------------------------------------------
// tb_vfifo_fifo_sc
// Directed bench for vfifo_fifo_sc: one standard-mode and one FWFT-mode
// instance (DATA_WIDTH 8, ADDR_WIDTH 4, AFULL 12, AEMPTY 4).
// ---------------------------------------------------------------------------
module tb_vfifo_fifo_sc;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Standard-mode instance signals
    logic       rst_s = 1'b0, wr_s = 1'b0, rd_s = 1'b0;
    logic [7:0] d_s = '0, q_s;
    logic       full_s, afull_s, empty_s, aempty_s, ovf_s, unf_s;
    logic [4:0] count_s;

    // FWFT-mode instance signals
    logic       rst_f = 1'b0, wr_f = 1'b0, rd_f = 1'b0;
    logic [7:0] d_f = '0, q_f;
    logic       full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
    logic [4:0] count_f;

    int total_cnt = 0;
    int pass_cnt  = 0;

    vfifo_fifo_sc #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0),
        .AFULL_LEVEL(12), .AEMPTY_LEVEL(4)
    ) dut_std (
        .clk(clk), .rst(rst_s), .d(d_s), .wr(wr_s), .full(full_s),
        .afull(afull_s), .rd(rd_s), .q(q_s), .empty(empty_s),
        .aempty(aempty_s), .count(count_s), .overflow(ovf_s),
        .underflow(unf_s)
    );

    vfifo_fifo_sc #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1),
        .AFULL_LEVEL(12), .AEMPTY_LEVEL(4)
    ) dut_fwft (
        .clk(clk), .rst(rst_f), .d(d_f), .wr(wr_f), .full(full_f),
        .afull(afull_f), .rd(rd_f), .q(q_f), .empty(empty_f),
        .aempty(aempty_f), .count(count_f), .overflow(ovf_f),
        .underflow(unf_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        // ---------------- standard mode: reset ----------------
        #1;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        chk("std_rst_count",  32'(count_s),  32'd0);
        chk("std_rst_empty",  32'(empty_s),  32'd1);
        chk("std_rst_aempty", 32'(aempty_s), 32'd1);
        chk("std_rst_full",   32'(full_s),   32'd0);
        chk("std_rst_afull",  32'(afull_s),  32'd0);
        chk("std_rst_ovf",    32'(ovf_s),    32'd0);
        chk("std_rst_unf",    32'(unf_s),    32'd0);

        // ---------------- fill 0x00..0x0F ----------------
        for (int i = 0; i < 16; i++) begin
            d_s  = 8'(i);
            wr_s = 1'b1;
            tick();
            chk("fill_count",  32'(count_s),  32'(i + 1));
            chk("fill_full",   32'(full_s),   32'((i + 1) == 16));
            chk("fill_afull",  32'(afull_s),  32'((i + 1) >= 12));
            chk("fill_aempty", 32'(aempty_s), 32'((i + 1) <= 4));
            chk("fill_empty",  32'(empty_s),  32'd0);
        end

        // 17th write is dropped and pulses overflow for one cycle
        d_s = 8'hAA;
        tick();
        wr_s = 1'b0;
        chk("ovf_pulse",     32'(ovf_s),   32'd1);
        chk("ovf_count",     32'(count_s), 32'd16);
        tick();
        chk("ovf_pulse_end", 32'(ovf_s),   32'd0);
        chk("ovf_count2",    32'(count_s), 32'd16);

        // ---------------- drain 16 words ----------------
        for (int i = 0; i < 16; i++) begin
            rd_s = 1'b1;
            tick();
            chk("drain_q",     32'(q_s),     32'(i));
            chk("drain_count", 32'(count_s), 32'(15 - i));
            chk("drain_empty", 32'(empty_s), 32'(i == 15));
        end

        // extra read pulses underflow, q holds last word
        tick();
        rd_s = 1'b0;
        chk("unf_pulse",     32'(unf_s),   32'd1);
        chk("unf_q_hold",    32'(q_s),     32'h0F);
        chk("unf_count",     32'(count_s), 32'd0);
        tick();
        chk("unf_pulse_end", 32'(unf_s),   32'd0);
        chk("unf_q_hold2",   32'(q_s),     32'h0F);

        // ---------------- streaming at count 3 ----------------
        wr_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_s = 8'(8'h10 + i);
            tick();
        end
        chk("stream_pre_count", 32'(count_s), 32'd3);
        rd_s = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d_s = 8'(8'h13 + i);
            tick();
            chk("stream_count", 32'(count_s), 32'd3);
            chk("stream_q",     32'(q_s),     32'(8'h10 + i));
        end
        rd_s = 1'b0;

        // ---------------- reset mid-operation with count 9 ----------------
        for (int i = 0; i < 6; i++) begin
            d_s = 8'(8'h40 + i);
            tick();
        end
        chk("pre_rst_count", 32'(count_s), 32'd9);
        rst_s = 1'b1;
        rd_s  = 1'b1;
        tick();
        rst_s = 1'b0;
        wr_s  = 1'b0;
        rd_s  = 1'b0;
        chk("mid_rst_count",  32'(count_s),  32'd0);
        chk("mid_rst_empty",  32'(empty_s),  32'd1);
        chk("mid_rst_aempty", 32'(aempty_s), 32'd1);
        chk("mid_rst_full",   32'(full_s),   32'd0);
        chk("mid_rst_ovf",    32'(ovf_s),    32'd0);
        chk("mid_rst_unf",    32'(unf_s),    32'd0);
        d_s  = 8'h77;
        wr_s = 1'b1;
        tick();
        wr_s = 1'b0;
        chk("post_rst_count", 32'(count_s), 32'd1);
        rd_s = 1'b1;
        tick();
        rd_s = 1'b0;
        chk("post_rst_q",     32'(q_s),     32'h77);
        chk("post_rst_empty", 32'(empty_s), 32'd1);
        chk("post_rst_unf",   32'(unf_s),   32'd0);

        // ---------------- FWFT mode ----------------
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        chk("fw_rst_empty", 32'(empty_f), 32'd1);
        chk("fw_rst_count", 32'(count_f), 32'd0);

        // single word: counted after edge k, visible after edge k+1
        d_f  = 8'h5A;
        wr_f = 1'b1;
        tick();
        wr_f = 1'b0;
        chk("fw_k_count",  32'(count_f), 32'd1);
        chk("fw_k_empty",  32'(empty_f), 32'd1);
        tick();
        chk("fw_k1_empty", 32'(empty_f), 32'd0);
        chk("fw_k1_q",     32'(q_f),     32'h5A);
        rd_f = 1'b1;
        tick();
        rd_f = 1'b0;
        chk("fw_pop_empty", 32'(empty_f), 32'd1);
        chk("fw_pop_count", 32'(count_f), 32'd0);
        chk("fw_pop_unf",   32'(unf_f),   32'd0);

        // back-to-back pops expose the next word immediately
        wr_f = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_f = 8'(8'hA1 + i);
            tick();
        end
        wr_f = 1'b0;
        tick();
        chk("fw_multi_q",     32'(q_f),     32'hA1);
        chk("fw_multi_count", 32'(count_f), 32'd3);
        rd_f = 1'b1;
        tick();
        chk("fw_pop1_q",     32'(q_f),     32'hA2);
        chk("fw_pop1_empty", 32'(empty_f), 32'd0);
        tick();
        chk("fw_pop2_q",     32'(q_f),     32'hA3);
        chk("fw_pop2_count", 32'(count_f), 32'd1);
        tick();
        rd_f = 1'b0;
        chk("fw_pop3_empty", 32'(empty_f), 32'd1);
        chk("fw_pop3_count", 32'(count_f), 32'd0);

        // pop + write at count 1: empty pulses while the new word settles
        d_f  = 8'hB1;
        wr_f = 1'b1;
        tick();
        wr_f = 1'b0;
        tick();
        chk("fw_b1_q", 32'(q_f), 32'hB1);
        d_f  = 8'hB2;
        wr_f = 1'b1;
        rd_f = 1'b1;
        tick();
        wr_f = 1'b0;
        rd_f = 1'b0;
        chk("fw_pulse_count", 32'(count_f), 32'd1);
        chk("fw_pulse_empty", 32'(empty_f), 32'd1);
        tick();
        chk("fw_after_empty", 32'(empty_f), 32'd0);
        chk("fw_after_q",     32'(q_f),     32'hB2);

        // read while empty in FWFT pulses underflow
        rd_f = 1'b1;
        tick();
        rd_f = 1'b1;
        tick();
        rd_f = 1'b0;
        chk("fw_unf_pulse", 32'(unf_f),   32'd1);
        chk("fw_unf_count", 32'(count_f), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
